// File: rtl/iiitb_usr_param_if.sv
// Bus bundle for the parametrised universal shift register: op controls, burst request,
// serial taps and the busy/done handshake.
interface iiitb_usr_param_if #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) ();
   logic             en;
   logic [2:0]       ctrl;
   logic [WIDTH-1:0] d;
   logic             sin_r;
   logic             sin_l;
   logic             start;
   logic [AW-1:0]    amt;
   logic [WIDTH-1:0] q;
   logic             sout_r;
   logic             sout_l;
   logic             busy;
   logic             done;

   modport master (
      output en, ctrl, d, sin_r, sin_l, start, amt,
      input  q, sout_r, sout_l, busy, done
   );

   modport slave (
      input  en, ctrl, d, sin_r, sin_l, start, amt,
      output q, sout_r, sout_l, busy, done
   );
endinterface

// File: rtl/iiitb_usr_param.sv
// Parametrised universal shift/rotate register with single-step ops and a
// multi-cycle burst shift reported through busy/done.
module iiitb_usr_param #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input logic              clk,
   input logic              reset,
   iiitb_usr_param_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_q, w_q_nxt;
   logic [2:0]       r_op, w_op_nxt;
   logic [AW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_busy, r_done;

   function automatic logic [WIDTH-1:0] f_step(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] v,
      input logic             sr,
      input logic             sl,
      input logic [WIDTH-1:0] ld
   );
      case (op)
         3'b001:  return {sr, v[WIDTH-1:1]};
         3'b010:  return {v[WIDTH-2:0], sl};
         3'b011:  return ld;
         3'b100:  return {v[0], v[WIDTH-1:1]};
         3'b101:  return {v[WIDTH-2:0], v[WIDTH-1]};
         3'b110:  return {v[WIDTH-1], v[WIDTH-1:1]};
         3'b111:  return '0;
         default: return v;
      endcase
   endfunction

   // Only ops that move bits can be repeated as a burst; others fall back to one step.
   function automatic logic f_is_shift(input logic [2:0] op);
      return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) ||
             (op == 3'b101) || (op == 3'b110);
   endfunction

   always_comb begin
      w_state_nxt = r_state;
      w_q_nxt     = r_q;
      w_op_nxt    = r_op;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_RUN: begin
            w_q_nxt   = f_step(r_op, r_q, bus.sin_r, bus.sin_l, bus.d);
            w_cnt_nxt = r_cnt - {{(AW-1){1'b0}}, 1'b1};
            if (r_cnt == {{(AW-1){1'b0}}, 1'b1}) w_state_nxt = S_FIN;
         end
         default: begin
            // FIN accepts inputs exactly like IDLE so a start in the done cycle is taken.
            w_state_nxt = S_IDLE;
            if (bus.en) begin
               if (bus.start && f_is_shift(bus.ctrl)) begin
                  w_op_nxt    = bus.ctrl;
                  w_cnt_nxt   = bus.amt;
                  w_state_nxt = (bus.amt != '0) ? S_RUN : S_FIN;
               end else begin
                  w_q_nxt = f_step(bus.ctrl, r_q, bus.sin_r, bus.sin_l, bus.d);
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_q     <= '0;
         r_op    <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_q     <= w_q_nxt;
         r_op    <= w_op_nxt;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_state_nxt == S_RUN);
         r_done  <= (w_state_nxt == S_FIN);
      end
   end

   assign bus.q      = r_q;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.sout_r = r_q[0];
   assign bus.sout_l = r_q[WIDTH-1];

endmodule

// File: tb/tb_iiitb_usr_param.sv
// Scoreboard bench for iiitb_usr_param: a cycle reference model feeds expectation
// queues that a negedge monitor drains against the DUT outputs.
module tb_iiitb_usr_param;
   localparam int W  = 8;
   localparam int AW = 4;

   typedef struct {
      logic [W-1:0] q;
      logic         busy;
      logic         done;
   } exp_t;

   logic clk;
   logic reset;
   iiitb_usr_param_if #(.WIDTH(W), .AW(AW)) bus ();

   iiitb_usr_param #(.WIDTH(W), .AW(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int dut_dones = 0;
   exp_t         exp_q[$];
   logic [W-1:0] done_q[$];

   // Reference model: remaining burst steps and the op being repeated.
   logic [W-1:0] m_q = '0;
   int           m_rem = 0;
   logic [2:0]   m_op = '0;
   logic         m_fin = 1'b0;
   logic         m_push_done = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_step(input logic [2:0] op, input logic [W-1:0] v,
                                             input logic sr, input logic sl, input logic [W-1:0] ld);
      logic signed [W-1:0] s;
      s = v;
      case (op)
         3'd1:    return (v >> 1) | (W'(sr) << (W-1));
         3'd2:    return (v << 1) | W'(sl);
         3'd3:    return ld;
         3'd4:    return (v >> 1) | (v << (W-1));
         3'd5:    return (v << 1) | (v >> (W-1));
         3'd6:    return W'(s >>> 1);
         3'd7:    return '0;
         default: return v;
      endcase
   endfunction

   function automatic bit is_shift(input logic [2:0] op);
      return op inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
   endfunction

   task automatic model_edge();
      m_push_done = 1'b0;
      if (!reset) begin
         m_q = '0; m_rem = 0; m_fin = 1'b0;
      end else if (m_rem > 0) begin
         m_q   = ref_step(m_op, m_q, bus.sin_r, bus.sin_l, bus.d);
         m_rem = m_rem - 1;
         m_fin = (m_rem == 0);
         m_push_done = m_fin;
      end else begin
         m_fin = 1'b0;
         if (bus.en) begin
            if (bus.start && is_shift(bus.ctrl)) begin
               m_op  = bus.ctrl;
               m_rem = int'(bus.amt);
               if (m_rem == 0) begin
                  m_fin = 1'b1;
                  m_push_done = 1'b1;
               end
            end else begin
               m_q = ref_step(bus.ctrl, m_q, bus.sin_r, bus.sin_l, bus.d);
            end
         end
      end
   endtask

   task automatic step();
      exp_t e;
      model_edge();
      e.q = m_q; e.busy = (m_rem > 0); e.done = m_fin;
      @(posedge clk);
      exp_q.push_back(e);
      if (m_push_done) done_q.push_back(m_q);
      #2;
   endtask

   task automatic drive(input logic en, input logic [2:0] ctrl, input logic [W-1:0] d,
                        input logic sr, input logic sl, input logic st, input logic [AW-1:0] amt);
      bus.en = en; bus.ctrl = ctrl; bus.d = d; bus.sin_r = sr;
      bus.sin_l = sl; bus.start = st; bus.amt = amt;
   endtask

   task automatic load(input logic [W-1:0] v);
      drive(1'b1, 3'd3, v, 1'b0, 1'b0, 1'b0, '0);
      step();
   endtask

   // Issues a burst and runs until done; noisy drives conflicting inputs while busy.
   task automatic burst(input logic [2:0] op, input logic [AW-1:0] amt, input bit noisy,
                        output int nbusy);
      int n;
      nbusy = 0;
      drive(1'b1, op, 8'h00, 1'b0, 1'b0, 1'b1, amt);
      step();
      if (bus.busy) nbusy++;
      if (noisy) drive(1'b1, 3'd3, 8'hFF, 1'b1, 1'b1, 1'b1, 4'd7);
      else       drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
      n = 0;
      while (!bus.done && n < 40) begin
         step();
         if (bus.busy) nbusy++;
         n++;
      end
      if (!bus.done) check("burst_timeout", 32'd0, 32'd1);
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("mon_q", 32'(bus.q), 32'(e.q));
         check("mon_busy", 32'(bus.busy), 32'(e.busy));
         check("mon_done", 32'(bus.done), 32'(e.done));
         check("mon_sout_r", 32'(bus.sout_r), 32'(e.q[0]));
         check("mon_sout_l", 32'(bus.sout_l), 32'(e.q[W-1]));
      end
      if (bus.done === 1'b1) begin
         dut_dones++;
         if (done_q.size() == 0) check("done_unexpected", 32'd1, 32'd0);
         else check("done_final_q", 32'(bus.q), 32'(done_q.pop_front()));
      end
   end

   initial begin
      int nb;
      int d0;
      reset = 1'b0;
      drive(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 4'($urandom));
      #3;
      check("rst_q", 32'(bus.q), 32'h00);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      step(); step();
      reset = 1'b1;
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
      step(); step();
      check("rel_q", 32'(bus.q), 32'h00);

      // Single steps
      load(8'h96);
      check("load", 32'(bus.q), 32'h96);
      drive(1'b1, 3'd1, 8'h00, 1'b1, 1'b0, 1'b0, '0); step();
      check("srl", 32'(bus.q), 32'hCB);
      check("srl_sout_r", 32'(bus.sout_r), 32'd1);
      drive(1'b1, 3'd2, 8'h00, 1'b0, 1'b0, 1'b0, '0); step();
      check("sll", 32'(bus.q), 32'h96);
      drive(1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 1'b0, '0); step();
      check("clear", 32'(bus.q), 32'h00);

      // Rotate bursts
      load(8'h96);
      burst(3'd4, 4'd3, 1'b0, nb);
      check("ror3_q", 32'(bus.q), 32'hD2);
      check("ror3_busy", 32'(nb), 32'd3);
      load(8'h96);
      burst(3'd5, 4'd8, 1'b0, nb);
      check("rol8_q", 32'(bus.q), 32'h96);
      check("rol8_busy", 32'(nb), 32'd8);

      // SRA and zero-length burst
      load(8'h96);
      burst(3'd6, 4'd4, 1'b0, nb);
      check("sra4_q", 32'(bus.q), 32'hF9);
      burst(3'd4, 4'd0, 1'b0, nb);
      check("amt0_busy", 32'(nb), 32'd0);
      check("amt0_q", 32'(bus.q), 32'hF9);
      step();
      check("done_one_cycle", 32'(bus.done), 32'd0);

      // Interference while busy
      load(8'h96);
      burst(3'd5, 4'd5, 1'b1, nb);
      check("rol5_noisy_q", 32'(bus.q), 32'hD2);
      check("rol5_busy", 32'(nb), 32'd5);

      // Abort mid-burst
      load(8'h96);
      d0 = dut_dones;
      drive(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b1, 4'd6); step();
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0); step();
      reset = 1'b0;
      exp_q.delete();
      m_q = '0; m_rem = 0; m_fin = 1'b0;
      #1;
      check("abort_q", 32'(bus.q), 32'h00);
      check("abort_busy", 32'(bus.busy), 32'd0);
      step(); step();
      reset = 1'b1;
      repeat (8) step();
      check("abort_no_done", 32'(dut_dones - d0), 32'd0);

      // Back-to-back bursts
      load(8'h96);
      d0 = dut_dones;
      burst(3'd4, 4'd1, 1'b0, nb);
      burst(3'd4, 4'd2, 1'b0, nb);
      check("b2b_q", 32'(bus.q), 32'hD2);
      step(); step();
      check("b2b_dones", 32'(dut_dones - d0), 32'd2);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 3'($urandom), 8'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 12)));
         step();
      end
      drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
      repeat (20) step();
      @(negedge clk); #1;
      check("done_q_drained", 32'(done_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/iiitb_usr_param.md
Name: iiitb_usr_param

Overview:
- Parametrised successor to the 4-bit universal shift register (USR).
- Generalises width and adds serial inputs/outputs, rotate, arithmetic shift, clear, and a multi-cycle burst shift with a busy/done handshake.
- Sits in the datapath as a general shift/rotate unit. ctrl codes 000-011 keep the original 2-bit USR meaning (hold, shift right, shift left, parallel load).

Parameters:
- WIDTH, 8: register width in bits, >= 2.
- AW, 4: width of amt. Must satisfy 2^AW > WIDTH so a full-width burst is encodable.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- en  input  1  enables single-step ops and burst start
- ctrl  input  3  operation select (see Behaviour)
- d  input  WIDTH  parallel load data
- sin_r  input  1  serial bit entering the MSB on a logical right shift
- sin_l  input  1  serial bit entering the LSB on a left shift
- start  input  1  request a burst of amt steps of the ctrl operation
- amt  input  AW  burst step count
- q  output  WIDTH  register contents
- sout_r  output  1  q[0] (combinational from q)
- sout_l  output  1  q[WIDTH-1] (combinational from q)
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst completion

Behaviour:
- Reset (reset=0, asynchronous): q=0, busy=0, done=0, internal count=0, FSM=IDLE. Reset takes effect immediately, including mid-burst; an aborted burst produces no done pulse.
- ctrl encoding (one step):
  - 000 hold
  - 001 SRL: q <= {sin_r, q[W-1:1]}
  - 010 SLL: q <= {q[W-2:0], sin_l}
  - 011 load: q <= d
  - 100 ROR
  - 101 ROL
  - 110 SRA: q <= {q[W-1], q[W-1:1]}
  - 111 clear: q <= 0
- Shift-class codes are 001, 010, 100, 101, 110.
- FSM states: IDLE, RUN, FIN.
- IDLE, en=0: q holds; start is ignored.
- IDLE, en=1, start=0: apply one step of ctrl at the clock edge.
- IDLE, en=1, start=1, ctrl non-shift-class: behaves as a single step; no busy, no done.
- IDLE, en=1, start=1, ctrl shift-class:
  - Latch the op and count=amt. q is not modified at this edge.
  - amt>0: go to RUN, busy=1.
  - amt=0: go to FIN, busy stays 0.
- RUN:
  - Each edge: apply the latched op once, count--. sin_r/sin_l are sampled live at each step.
  - The edge applying the last step (count==1) goes to FIN and clears busy.
  - busy is high for exactly amt cycles.
  - en, ctrl, d, start and amt are ignored while busy.
- FIN: done=1 for exactly one cycle, then IDLE.
  - In FIN, inputs are treated as in IDLE, so a back-to-back start in the done cycle is accepted.
- amt > WIDTH is legal: steps are simply applied amt times (rotates wrap naturally; SRL/SLL fill with the sampled serial bits).
- Outputs q, busy and done are registered. sout_r and sout_l are combinational from q.
- No X on any output after reset is released.

Test Plan (WIDTH=8, AW=4):
1. Reset: assert reset=0 with random inputs -> q=8'h00, busy=0, done=0; release reset with en=0 -> q stays 8'h00.
2. Single steps: load d=8'h96 (ctrl=011) -> q=8'h96; SRL with sin_r=1 -> q=8'hCB, sout_r=1; SLL with sin_l=0 -> q=8'h96; clear (111) -> q=8'h00.
3. Rotate burst: q=8'h96, start=1, ctrl=100, amt=3 -> busy=1 for 3 cycles, q=8'hD2 when busy falls, done=1 for one cycle. Repeat with ctrl=101, amt=8 -> q returns to 8'h96.
4. SRA burst and zero-length burst: q=8'h96, ctrl=110, amt=4 -> q=8'hF9 after 4 busy cycles, then done. Then start with amt=0 -> busy stays 0, done pulses one cycle later, q unchanged at 8'hF9.
5. Interference and abort:
   - During a ROL amt=5 burst, drive ctrl=011, d=8'hFF and start=1 -> ignored; final q equals the 5-step rotate.
   - Start a new burst and assert reset=0 during its 2nd busy cycle -> q=0 and busy=0 immediately; no done pulse follows.
6. Back-to-back: start a second ROR amt=2 burst in the done cycle of a first amt=1 burst -> accepted; total rotation of 3; exactly two done pulses.
